// File: rtl/iiitb_fifo_pkg.sv
// Shared defaults and count arithmetic for the parameterised FIFO.
package iiitb_fifo_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 3;
  localparam int unsigned DEF_AEMPTY_TH = 2;

  // almost_full default sits two entries below full
  function automatic int unsigned def_afull_th(input int unsigned addr_w);
    return (32'(1) << addr_w) - 32'(2);
  endfunction

  function automatic int unsigned count_next(input int unsigned cnt,
                                             input logic        wr_acc,
                                             input logic        rd_acc);
    case ({wr_acc, rd_acc})
      2'b10:   return cnt + 32'(1);
      2'b01:   return cnt - 32'(1);
      default: return cnt;
    endcase
  endfunction

endpackage

// File: rtl/iiitb_param_fifo_if.sv
// FIFO data/handshake/status bundle; master drives requests, slave is the FIFO.
interface iiitb_param_fifo_if #(
  parameter int unsigned DATA_W = iiitb_fifo_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = iiitb_fifo_pkg::DEF_ADDR_W
) ();

  logic [DATA_W-1:0] buf_in;
  logic              wr_en;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] buf_out;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   fifo_counter;
  logic              overflow;
  logic              underflow;

  modport master (
    output buf_in, wr_en, rd_en, err_clr,
    input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

  modport slave (
    input  buf_in, wr_en, rd_en, err_clr,
    output buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

endinterface

// File: rtl/iiitb_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module iiitb_fifo_mem #(
  parameter int unsigned DATA_W = iiitb_fifo_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = iiitb_fifo_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/iiitb_param_fifo.sv
// Parameterised synchronous FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module iiitb_param_fifo
  import iiitb_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned AFULL_TH  = def_afull_th(ADDR_W),
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
  input logic              clk,
  input logic              rst_n,
  iiitb_param_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH < DEPTH)) begin : g_bad_th
    $error("iiitb_param_fifo: need 0 < AEMPTY_TH < AFULL_TH < DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, rd_addr;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] rd_data, out_q, out_nxt;
  logic              wr_acc, rd_acc;
  logic              empty_q, full_q, aempty_q, afull_q, ovf_q, udf_q;
  logic              ovf_nxt, udf_nxt;

  iiitb_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .we     (wr_acc),
    .waddr  (wr_ptr),
    .wdata  (bus.buf_in),
    .raddr  (rd_addr),
    .rdata_c(rd_data)
  );

  // Acceptance, pointer/count next-state, error and read-data selection
  always_comb begin
    rd_acc     = bus.rd_en && !empty_q;
    wr_acc     = bus.wr_en && (!full_q || rd_acc);
    wr_ptr_nxt = wr_acc ? wr_ptr + ADDR_W'(1) : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + ADDR_W'(1) : rd_ptr;
    cnt_nxt    = CNT_W'(count_next(32'(cnt), wr_acc, rd_acc));
    ovf_nxt    = (bus.wr_en && !wr_acc) ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    udf_nxt    = (bus.rd_en && !rd_acc) ? 1'b1 : (bus.err_clr ? 1'b0 : udf_q);
`ifdef FIFO_FWFT_EN
    // Preload the head that will be current after this edge; bypass a write into an emptying FIFO
    rd_addr = rd_ptr_nxt;
    if (cnt_nxt == '0)                       out_nxt = '0;
    else if (wr_acc && rd_ptr_nxt == wr_ptr) out_nxt = bus.buf_in;
    else                                     out_nxt = rd_data;
`else
    rd_addr = rd_ptr;
    out_nxt = rd_acc ? rd_data : out_q;
`endif
  end

  // State and registered outputs; flags are computed from the next count so they align with fifo_counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      out_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      cnt      <= cnt_nxt;
      out_q    <= out_nxt;
      empty_q  <= (cnt_nxt == '0);
      full_q   <= (cnt_nxt == CNT_W'(DEPTH));
      aempty_q <= (cnt_nxt <= CNT_W'(AEMPTY_TH));
      afull_q  <= (cnt_nxt >= CNT_W'(AFULL_TH));
      ovf_q    <= ovf_nxt;
      udf_q    <= udf_nxt;
    end
  end

  assign bus.buf_out      = out_q;
  assign bus.buf_empty    = empty_q;
  assign bus.buf_full     = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.fifo_counter = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_iiitb_param_fifo.sv
// Directed bench for iiitb_param_fifo (DATA_W=8, ADDR_W=3); read timing follows FIFO_FWFT_EN.
module tb_iiitb_param_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iiitb_param_fifo_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  iiitb_param_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit         wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    bit         empty, full, ae, af, ovf, udf;
    logic [7:0] out_reg, out_fwft;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit wr, bit rd, bit clr, logic [7:0] din, int cnt,
                              bit e, bit f, bit ae, bit af, bit ov, bit ud,
                              logic [7:0] oreg, logic [7:0] ofwft);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.empty = e; v.full = f; v.ae = ae; v.af = af; v.ovf = ov; v.udf = ud;
    v.out_reg = oreg; v.out_fwft = ofwft;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.err_clr = 1'b0; bus.buf_in = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt"},   32'(bus.fifo_counter), 0);
    chk({tag, "_out"},   32'(bus.buf_out), 0);
    chk({tag, "_empty"}, 32'(bus.buf_empty), 1);
    chk({tag, "_ae"},    32'(bus.almost_empty), 1);
    chk({tag, "_full"},  32'(bus.buf_full), 0);
    chk({tag, "_af"},    32'(bus.almost_full), 0);
    chk({tag, "_ovf"},   32'(bus.overflow), 0);
    chk({tag, "_udf"},   32'(bus.underflow), 0);
  endtask

  // One cycle against a queue model; read data is checked where each mode presents it
  task automatic op(input string tag, input bit w, input bit r, input logic [7:0] d);
    bit         racc, wacc;
    logic [7:0] exp;
    racc = r && (mq.size() > 0);
    wacc = w && (mq.size() < 8 || racc);
    exp  = racc ? mq[0] : 8'h00;
`ifdef FIFO_FWFT_EN
    if (racc) chk({tag, "_head"}, 32'(bus.buf_out), 32'(exp));
`endif
    bus.wr_en = w; bus.rd_en = r; bus.buf_in = d;
    @(posedge clk); #1;
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(d);
`ifndef FIFO_FWFT_EN
    if (racc) chk({tag, "_rdata"}, 32'(bus.buf_out), 32'(exp));
`endif
    chk({tag, "_cnt"}, 32'(bus.fifo_counter), 32'(mq.size()));
    idle_inputs();
  endtask

  initial begin
    // Directed table: {wr rd clr din | cnt empty full ae af ovf udf | out_reg out_fwft}
    vecs.push_back(mk(1,0,0,  1, 1,0,0,1,0,0,0,  0,  1));
    vecs.push_back(mk(1,0,0,  2, 2,0,0,1,0,0,0,  0,  1));
    vecs.push_back(mk(1,0,0,  3, 3,0,0,0,0,0,0,  0,  1));
    vecs.push_back(mk(0,1,0,  0, 2,0,0,1,0,0,0,  1,  2));
    vecs.push_back(mk(0,1,0,  0, 1,0,0,1,0,0,0,  2,  3));
    vecs.push_back(mk(0,1,0,  0, 0,1,0,1,0,0,0,  3,  0));
    vecs.push_back(mk(1,0,0, 10, 1,0,0,1,0,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 20, 2,0,0,1,0,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 30, 3,0,0,0,0,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 40, 4,0,0,0,0,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 50, 5,0,0,0,0,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 60, 6,0,0,0,1,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 70, 7,0,0,0,1,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 80, 8,0,1,0,1,0,0,  3, 10));
    vecs.push_back(mk(1,0,0, 90, 8,0,1,0,1,1,0,  3, 10));
    vecs.push_back(mk(0,0,1,  0, 8,0,1,0,1,0,0,  3, 10));
    vecs.push_back(mk(1,1,0, 99, 8,0,1,0,1,0,0, 10, 20));
    vecs.push_back(mk(0,1,0,  0, 7,0,0,0,1,0,0, 20, 30));
    vecs.push_back(mk(0,1,0,  0, 6,0,0,0,1,0,0, 30, 40));
    vecs.push_back(mk(0,1,0,  0, 5,0,0,0,0,0,0, 40, 50));
    vecs.push_back(mk(0,1,0,  0, 4,0,0,0,0,0,0, 50, 60));
    vecs.push_back(mk(0,1,0,  0, 3,0,0,0,0,0,0, 60, 70));
    vecs.push_back(mk(0,1,0,  0, 2,0,0,1,0,0,0, 70, 80));
    vecs.push_back(mk(0,1,0,  0, 1,0,0,1,0,0,0, 80, 99));
    vecs.push_back(mk(0,1,0,  0, 0,1,0,1,0,0,0, 99,  0));
    vecs.push_back(mk(1,1,0,  5, 1,0,0,1,0,0,1, 99,  5));
    vecs.push_back(mk(0,1,0,  0, 0,1,0,1,0,0,1,  5,  0));
    vecs.push_back(mk(0,0,1,  0, 0,1,0,1,0,0,0,  5,  0));
    vecs.push_back(mk(0,1,1,  0, 0,1,0,1,0,0,1,  5,  0));
    vecs.push_back(mk(0,0,1,  0, 0,1,0,1,0,0,0,  5,  0));

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_reset_outputs("por");
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      logic [7:0] eo;
      v = vecs[i];
      bus.wr_en = v.wr; bus.rd_en = v.rd; bus.err_clr = v.clr; bus.buf_in = v.din;
      @(posedge clk); #1;
`ifdef FIFO_FWFT_EN
      eo = v.out_fwft;
`else
      eo = v.out_reg;
`endif
      chk($sformatf("v%0d_cnt", i),   32'(bus.fifo_counter), 32'(v.cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus.buf_empty),    32'(v.empty));
      chk($sformatf("v%0d_full", i),  32'(bus.buf_full),     32'(v.full));
      chk($sformatf("v%0d_ae", i),    32'(bus.almost_empty), 32'(v.ae));
      chk($sformatf("v%0d_af", i),    32'(bus.almost_full),  32'(v.af));
      chk($sformatf("v%0d_ovf", i),   32'(bus.overflow),     32'(v.ovf));
      chk($sformatf("v%0d_udf", i),   32'(bus.underflow),    32'(v.udf));
      chk($sformatf("v%0d_out", i),   32'(bus.buf_out),      32'(eo));
      idle_inputs();
    end

    // Twelve writes with interleaved reads, wrapping both pointers, then drain
    for (int i = 0; i < 12; i++)
      op($sformatf("wrap%0d", i), 1'b1, (i >= 2) && (i % 2 == 0), 8'(100 + i));
    for (int i = 0; i < 8 && mq.size() > 0; i++)
      op($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);
    chk("drain_empty", 32'(bus.buf_empty), 1);

    // Asynchronous reset with four entries held
    for (int i = 0; i < 4; i++) op($sformatf("pre%0d", i), 1'b1, 1'b0, 8'(200 + i));
    chk("pre_cnt4", 32'(bus.fifo_counter), 4);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    mq.delete();
    bus.wr_en = 1'b1; bus.buf_in = 8'hEE;
    @(posedge clk); #1;
    chk("rst_no_sample", 32'(bus.fifo_counter), 0);
    idle_inputs();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contents discarded: basic order check again after release
    op("r1", 1'b1, 1'b0, 8'd1);
    op("r2", 1'b1, 1'b0, 8'd2);
    op("r3", 1'b1, 1'b0, 8'd3);
    op("r4", 1'b0, 1'b1, 8'd0);
    op("r5", 1'b0, 1'b1, 8'd0);
    op("r6", 1'b0, 1'b1, 8'd0);
    chk("post_rst_empty", 32'(bus.buf_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iiitb_param_fifo.md
IIITB_PARAM_FIFO -- requirements
Module: iiitb_param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, log2 of depth (DEPTH = 2**ADDR_W).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost_empty asserts when count <= AEMPTY_TH.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 buf_in  in  DATA_W  write data.
REQ-008 wr_en  in  1  write request.
REQ-009 rd_en  in  1  read request.
REQ-010 err_clr  in  1  clears sticky error flags.
REQ-011 buf_out  out  DATA_W  read data.
REQ-012 buf_empty / buf_full  out  1 each  count==0 / count==DEPTH.
REQ-013 almost_empty / almost_full  out  1 each  threshold flags per REQ-003/004.
REQ-014 fifo_counter  out  ADDR_W+1  current occupancy 0..DEPTH.
REQ-015 overflow / underflow  out  1 each  sticky rejected-write / rejected-read flags.

Function
REQ-016 Write accepted iff wr_en && (!buf_full || read accepted same cycle); data stored at wr_ptr, wr_ptr increments mod DEPTH.
REQ-017 Read accepted iff rd_en && !buf_empty; rd_ptr increments mod DEPTH.
REQ-018 Empty + simultaneous wr_en/rd_en: write accepted, read rejected, underflow set, count -> 1.
REQ-019 Full + simultaneous wr_en/rd_en: both accepted, count stays DEPTH, no overflow.
REQ-020 Count: +1 write-only, -1 read-only, unchanged both/neither; never exceeds DEPTH or goes below 0.
REQ-021 All flags derived from registered count and valid in the same cycle as fifo_counter.
REQ-022 Rejected write (wr_en && full && no accepted read) sets overflow; memory, pointers, count unchanged.
REQ-023 Rejected read (rd_en && empty) sets underflow; buf_out holds previous value.
REQ-024 overflow/underflow stay set until err_clr=1 at a clock edge; a new error coincident with err_clr wins (flag stays 1).
REQ-025 Pointers wrap DEPTH-1 -> 0 with no loss; order strictly first-in first-out.

Reset
REQ-026 rst_n low SHALL asynchronously force pointers=0, count=0, buf_out=0, buf_empty=1, almost_empty=1, buf_full=0, almost_full=0, overflow=0, underflow=0.
REQ-027 Reset mid-operation discards all contents; memory array is not cleared; first accepted write after release lands at address 0.
REQ-028 Release is synchronous to clk; no request sampled on the edge where rst_n is low.

Configuration
REQ-029 Macro FIFO_FWFT_EN selects read mode.
REQ-030 Undefined: registered read; buf_out updates on the edge accepting the read (valid 1 cycle after rd_en asserted); holds otherwise.
REQ-031 Defined: first-word fall-through; buf_out shows head entry whenever !buf_empty; accepted read advances to next entry on that edge; buf_out = 0 when empty.
REQ-032 Flag, count and error behaviour identical in both modes.

Structure
REQ-033 Shared package iiitb_fifo_pkg SHALL hold defaults DATA_W/ADDR_W/thresholds and a function for count-next arithmetic.
REQ-034 Storage SHALL be sub-module iiitb_fifo_mem: one write port, one async read port, DEPTH x DATA_W, no reset.
REQ-035 Threshold parameters SHALL be checked at elaboration: 0 < AEMPTY_TH < AFULL_TH < DEPTH.

Verification (DATA_W=8, ADDR_W=3)
REQ-036 Reset, write 1,2,3, read 3 -> outputs 1,2,3 in order; count 3->0; buf_empty=1 after last read.
REQ-037 Write 10..80 (8 words) -> buf_full=1, count=8, almost_full from count 6; 9th write 90 -> overflow=1, read returns 10.
REQ-038 Full, simultaneous write 99 + read -> read 10, count stays 8, no overflow; drain yields 20..80, 99.
REQ-039 Empty, simultaneous write 5 + read -> underflow=1, count=1; next read returns 5; err_clr clears underflow.
REQ-040 Write 12 words with interleaved reads crossing pointer wrap -> strict FIFO order, count tracks exactly.
REQ-041 Assert rst_n low with count=4 mid-burst -> all outputs per REQ-026 immediately, without clk edge; run REQ-036 in both FIFO_FWFT_EN builds.
